// File: rtl/peak_reader.sv
// peak_reader: buffers spectral peak frames in a DEPTH-slot ring and serves them over an Avalon-MM read port.
// Define PEAK_READER_IRQ_EN to build the registered frame-available interrupt; otherwise irq is tied low.
module peak_reader #(
    parameter int PEAKS      = 6,
    parameter int AMPL_WIDTH = 16,
    parameter int FREQ_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic                             CLOCK_50,
    input  logic                             reset_n,
    input  logic                             valid_in,
    input  logic [PEAKS*AMPL_WIDTH-1:0]      amplitude,
    input  logic [PEAKS*FREQ_WIDTH-1:0]      freq,
    input  logic                             chipselect,
    input  logic                             read,
    input  logic [1:0]                       address,
    output logic [31:0]                      readdata,
    output logic                             irq
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int EW = PEAKS > 1 ? $clog2(PEAKS) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [EW-1:0] LAST_ENT = EW'(PEAKS - 1);
    localparam logic [3:0]    FULL     = 4'(DEPTH);
    logic [AMPL_WIDTH-1:0] amp_mem  [DEPTH][PEAKS];
    logic [FREQ_WIDTH-1:0] freq_mem [DEPTH][PEAKS];
    logic [15:0]           fidx_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] ent_q, ent_d;
    logic [3:0]    count_q, count_d;
    logic [15:0]   fidx_q, fidx_d, head;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d, status_w, pop_w;
    logic          rd_en, empty, pop, last, accept, drop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == LAST_PTR ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        rd_en    = chipselect && read;
        empty    = count_q == 4'd0;
        pop      = rd_en && address == 2'd1 && !empty;
        last     = pop && ent_q == LAST_ENT;
        // acceptance looks at the pre-pop count, so a full ring drops even while a frame is freed
        accept   = valid_in && count_q != FULL;
        drop     = valid_in && count_q == FULL;
        wr_ptr_d = accept ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = last ? nxt(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + 4'(accept) - 4'(last);
        ent_d    = last ? '0 : pop ? ent_q + 1'b1 : ent_q;
        fidx_d   = fidx_q + 16'(valid_in);
        ovf_d    = drop || (ovf_q && !(rd_en && address == 2'd0));
        head     = empty ? 16'd0 : fidx_mem[rd_ptr_q];
        status_w = {head, 10'd0, ovf_q, empty, count_q};
        pop_w    = empty ? 32'd0 : (32'(freq_mem[rd_ptr_q][ent_q]) << 16) | 32'(amp_mem[rd_ptr_q][ent_q]);
        rdata_d  = !rd_en ? rdata_q :
                   address == 2'd0 ? status_w :
                   address == 2'd1 ? pop_w :
                   address == 2'd2 ? {16'd0, fidx_q} : 32'd0;
    end
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ent_q    <= '0;
            count_q  <= '0;
            fidx_q   <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ent_q    <= ent_d;
            count_q  <= count_d;
            fidx_q   <= fidx_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end
    // slot storage is deliberately unreset; count == 0 masks it from every read
    always_ff @(posedge CLOCK_50) begin
        if (accept) begin
            for (int i = 0; i < PEAKS; i++) begin
                amp_mem[wr_ptr_q][i]  <= amplitude[i*AMPL_WIDTH +: AMPL_WIDTH];
                freq_mem[wr_ptr_q][i] <= freq[i*FREQ_WIDTH +: FREQ_WIDTH];
            end
            fidx_mem[wr_ptr_q] <= fidx_q;
        end
    end
    assign readdata = rdata_q;
`ifdef PEAK_READER_IRQ_EN
    logic irq_q;
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= count_q != 4'd0 || ovf_q;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule
